// File: rtl/subtract_32bit_if.sv
// Operand/result bundle for the registered subtractor.
// Flag signals exist only when SUB_FLAGS_EN is defined.
interface subtract_32bit_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] diff;
    logic             cout;
`ifdef SUB_FLAGS_EN
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             lt;
`endif

`ifdef SUB_FLAGS_EN
    modport master (
        output in_valid, a, b,
        input  out_valid, diff, cout, zero, neg, ovf, lt
    );
    modport slave (
        input  in_valid, a, b,
        output out_valid, diff, cout, zero, neg, ovf, lt
    );
`else
    modport master (
        output in_valid, a, b,
        input  out_valid, diff, cout
    );
    modport slave (
        input  in_valid, a, b,
        output out_valid, diff, cout
    );
`endif
endinterface

// File: rtl/subtract_32bit.sv
// Registered subtractor: {cout, diff} = a + ~b + 1 over rippled 4-bit CLA groups, 1-cycle latency.
// Optional zero/neg/ovf/lt flag outputs are built when SUB_FLAGS_EN is defined.
module subtract_32bit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            rst_n,
    subtract_32bit_if.slave bus
);

    localparam int GROUPS = WIDTH / 4;

    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] sum;
    logic [GROUPS:0]  group_carry;

    logic             out_valid_q;
    logic [WIDTH-1:0] diff_q;
    logic             cout_q;

    // Full lookahead inside a group: every carry is a sum of products of g/p and the group carry-in.
    function automatic logic [4:0] cla4(
        input logic [3:0] x,
        input logic [3:0] y,
        input logic       ci
    );
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        logic       prod;
        g    = x & y;
        p    = x ^ y;
        c    = 5'b0;
        c[0] = ci;
        for (int j = 0; j < 4; j++) begin
            c[j+1] = g[j];
            prod   = p[j];
            for (int k = j - 1; k >= 0; k--) begin
                c[j+1] = c[j+1] | (g[k] & prod);
                prod   = prod & p[k];
            end
            c[j+1] = c[j+1] | (prod & ci);
        end
        return {c[4], p ^ c[3:0]};
    endfunction

    assign b_inv          = ~bus.b;
    assign group_carry[0] = 1'b1;

    for (genvar gi = 0; gi < GROUPS; gi++) begin : g_cla
        assign {group_carry[gi+1], sum[gi*4 +: 4]} =
            cla4(bus.a[gi*4 +: 4], b_inv[gi*4 +: 4], group_carry[gi]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                diff_q <= sum;
                cout_q <= group_carry[GROUPS];
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.cout      = cout_q;

`ifdef SUB_FLAGS_EN
    logic zero_d;
    logic ovf_d;
    logic zero_q;
    logic neg_q;
    logic ovf_q;

    assign zero_d = (sum == '0);
    assign ovf_d  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.in_valid) begin
            zero_q <= zero_d;
            neg_q  <= sum[WIDTH-1];
            ovf_q  <= ovf_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.neg  = neg_q;
    assign bus.ovf  = ovf_q;
    assign bus.lt   = neg_q ^ ovf_q;
`endif

endmodule

// File: tb/tb_subtract_32bit.sv
// Self-checking bench for subtract_32bit: directed vector table, corner sequences, random compare.
module tb_subtract_32bit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    subtract_32bit_if #(.WIDTH(32)) bus ();

    subtract_32bit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        cout;
        logic        zero;
        logic        neg;
        logic        ovf;
        logic        lt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive operands at the falling edge, then look at outputs 1 ns after the capturing edge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string name, input logic z, input logic n, input logic o, input logic l);
`ifdef SUB_FLAGS_EN
        check({name, ".zero"}, {31'b0, bus.zero}, {31'b0, z});
        check({name, ".neg"},  {31'b0, bus.neg},  {31'b0, n});
        check({name, ".ovf"},  {31'b0, bus.ovf},  {31'b0, o});
        check({name, ".lt"},   {31'b0, bus.lt},   {31'b0, l});
`endif
    endtask

    vec_t vecs[$];
    logic [31:0] held_diff;
    logic        held_cout;
    logic        held_zero;
    logic        held_neg;
    logic        held_ovf;
    logic        held_lt;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;

        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0006, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9, 32'h0000_0006, 32'hFFFF_FFF3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h0000_0006, 32'h0000_0007, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32'h0000_0020, 32'h0000_0010, 32'h0000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});

        // Reset held with activity on the inputs: outputs must stay cleared.
        for (int i = 0; i < 4; i++) begin
            step(i[0], $urandom, $urandom);
            check("rst_hold.out_valid", {31'b0, bus.out_valid}, 32'd0);
            check("rst_hold.diff", bus.diff, 32'd0);
            check("rst_hold.cout", {31'b0, bus.cout}, 32'd0);
            check_flags("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed table, applied back-to-back; the last two entries are the 32-16 / 0x80000000-1 stream.
        foreach (vecs[i]) begin
            step(1'b1, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d.out_valid", i), {31'b0, bus.out_valid}, 32'd1);
            check($sformatf("vec%0d.diff", i), bus.diff, vecs[i].diff);
            check($sformatf("vec%0d.cout", i), {31'b0, bus.cout}, {31'b0, vecs[i].cout});
            check_flags($sformatf("vec%0d", i), vecs[i].zero, vecs[i].neg, vecs[i].ovf, vecs[i].lt);
        end

        // Idle cycle after the stream: valid drops, result holds even with new operand values.
        step(1'b0, 32'h0000_0005, 32'h0000_0009);
        check("idle.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("idle.diff", bus.diff, 32'h7FFF_FFFF);
        check("idle.cout", {31'b0, bus.cout}, 32'd1);
        check_flags("idle", 1'b0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset between edges while a result is valid.
        step(1'b1, 32'h0000_0064, 32'h0000_0001);
        check("pre_arst.diff", bus.diff, 32'h0000_0063);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst.diff", bus.diff, 32'd0);
        check("arst.cout", {31'b0, bus.cout}, 32'd0);
        check_flags("arst", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0003, 32'h0000_0001);
        check("arst_edge.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_edge.diff", bus.diff, 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step(1'b0, 32'h0000_0003, 32'h0000_0001);
        check("post_rst_idle.out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("post_rst_idle.diff", bus.diff, 32'd0);
        step(1'b1, 32'h0000_0003, 32'h0000_0001);
        check("post_rst_first.out_valid", {31'b0, bus.out_valid}, 32'd1);
        check("post_rst_first.diff", bus.diff, 32'd2);
        check("post_rst_first.cout", {31'b0, bus.cout}, 32'd1);

        // Random operands with random idle gaps, against plain integer arithmetic.
        held_diff = 32'd2;
        held_cout = 1'b1;
        held_zero = 1'b0;
        held_neg  = 1'b0;
        held_ovf  = 1'b0;
        held_lt   = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            logic        rv;
            longint      sd;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 15))
                0: rb = ra;
                1: rb = 32'd0;
                2: ra = 32'd0;
                3: rb = ra + 32'd1;
                default: ;
            endcase
            rv = ($urandom_range(0, 7) != 0);
            if (rv) begin
                sd = longint'($signed(ra)) - longint'($signed(rb));
                held_diff = ra - rb;
                held_cout = (ra >= rb);
                held_zero = (ra == rb);
                held_neg  = held_diff[31];
                held_ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
                held_lt   = ($signed(ra) < $signed(rb));
            end
            step(rv, ra, rb);
            check("rand.out_valid", {31'b0, bus.out_valid}, {31'b0, rv});
            check("rand.diff", bus.diff, held_diff);
            check("rand.cout", {31'b0, bus.cout}, {31'b0, held_cout});
            check_flags("rand", held_zero, held_neg, held_ovf, held_lt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
